// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, x/y raster counters and registered sync/blank.
// Define VGA_FRAME_TICK_EN to add the frame_tick output (one pulse at the start of vertical blank).

module vga_sync_gen #(
    parameter int PIX_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic       bright,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pix_en
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic       frame_tick
`endif
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_MAX  = 4'(PIX_DIV - 1);
    localparam logic [9:0] HT_M1    = 10'(HT - 1);
    localparam logic [9:0] VT_M1    = 10'(VT - 1);
    localparam logic [9:0] HA       = 10'(H_ACTIVE);
    localparam logic [9:0] VA       = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0] div;
    logic [3:0] div_next;
    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       bright_next;
    logic       hsync_next;
    logic       vsync_next;

    // Sync and blank are decoded from the upcoming position so they travel with x/y.
    always_comb begin
        div_next = (div == DIV_MAX) ? 4'd0 : div + 4'd1;
        x_next   = x + 10'd1;
        y_next   = y;
        if (x == HT_M1) begin
            x_next = '0;
            y_next = (y == VT_M1) ? 10'd0 : y + 10'd1;
        end
        bright_next = (x_next < HA) && (y_next < VA);
        hsync_next  = !((x_next >= HS_START) && (x_next < HS_END));
        vsync_next  = !((y_next >= VS_START) && (y_next < VS_END));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div    <= '0;
            pix_en <= 1'b0;
            x      <= '0;
            y      <= '0;
            bright <= 1'b0;
            hsync  <= 1'b1;
            vsync  <= 1'b1;
        end else begin
            div    <= div_next;
            pix_en <= (div_next == DIV_MAX);
            if (pix_en) begin
                x      <= x_next;
                y      <= y_next;
                bright <= bright_next;
                hsync  <= hsync_next;
                vsync  <= vsync_next;
            end
        end
    end

`ifdef VGA_FRAME_TICK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= pix_en && (x == HT_M1) && (y_next == VA);
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (reference-width line, PIX_DIV=1, tiny raster) checked
// against an arithmetic raster model derived from the elapsed clock count since reset.

module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic hs_a, vs_a, br_a, pe_a, hs_b, vs_b, br_b, pe_b, hs_c, vs_c, br_c, pe_c;
    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
`ifdef VGA_FRAME_TICK_EN
    logic ft_a, ft_b, ft_c;
`endif

    int tests = 0;
    int fails = 0;
    int t_a = 0, t_b = 0, t_c = 0;

    always @(posedge clk) begin
        t_a <= rst_a ? 0 : t_a + 1;
        t_b <= rst_b ? 0 : t_b + 1;
        t_c <= rst_c ? 0 : t_c + 1;
    end

    vga_sync_gen #(.PIX_DIV(4), .V_ACTIVE(2), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_a (
        .clk(clk), .rst(rst_a), .hsync(hs_a), .vsync(vs_a), .bright(br_a),
        .x(x_a), .y(y_a), .pix_en(pe_a)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(ft_a)
`endif
    );

    vga_sync_gen #(.PIX_DIV(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_b (
        .clk(clk), .rst(rst_b), .hsync(hs_b), .vsync(vs_b), .bright(br_b),
        .x(x_b), .y(y_b), .pix_en(pe_b)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(ft_b)
`endif
    );

    vga_sync_gen #(.PIX_DIV(3), .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
                   .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(4)) dut_c (
        .clk(clk), .rst(rst_c), .hsync(hs_c), .vsync(vs_c), .bright(br_c),
        .x(x_c), .y(y_c), .pix_en(pe_c)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(ft_c)
`endif
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       br;
        logic       pe;
        logic       ft;
    } exp_t;

    // t = clocks since the last reset edge; n = pixels completed so far.
    function automatic exp_t model(input int t, input int d, input int ha, input int hfp,
                                   input int hsw, input int hbp, input int va, input int vfp,
                                   input int vsw, input int vbp);
        exp_t e;
        int ht, vt, n, px, ln;
        bit fresh;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        n  = (d > 1) ? t / d : ((t == 0) ? 0 : t - 1);
        px = n % ht;
        ln = (n / ht) % vt;
        fresh = (d > 1) ? (t > 0 && t % d == 0) : (t >= 2);
        e.x  = 10'(px);
        e.y  = 10'(ln);
        e.pe = (t > 0) && (t % d == d - 1);
        e.br = (n > 0) && (px < ha) && (ln < va);
        e.hs = !((n > 0) && (px >= ha + hfp) && (px < ha + hfp + hsw));
        e.vs = !((n > 0) && (ln >= va + vfp) && (ln < va + vfp + vsw));
        e.ft = fresh && (px == 0) && (ln == va);
        return e;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            tests++;
            if ({x_a, y_a, hs_a, vs_a, br_a, pe_a} !== {20'd0, 4'b1100}) begin
                fails++;
                $display("FAIL reset_a: x=%0d y=%0d hs=%b vs=%b br=%b pe=%b, want 0 0 1 1 0 0",
                         x_a, y_a, hs_a, vs_a, br_a, pe_a);
            end
            tests++;
            if ({x_b, y_b, hs_b, vs_b, br_b, pe_b} !== {20'd0, 4'b1100}) begin
                fails++;
                $display("FAIL reset_b: x=%0d y=%0d hs=%b vs=%b br=%b pe=%b, want 0 0 1 1 0 0",
                         x_b, y_b, hs_b, vs_b, br_b, pe_b);
            end
            tests++;
            if ({x_c, y_c, hs_c, vs_c, br_c, pe_c} !== {20'd0, 4'b1100}) begin
                fails++;
                $display("FAIL reset_c: x=%0d y=%0d hs=%b vs=%b br=%b pe=%b, want 0 0 1 1 0 0",
                         x_c, y_c, hs_c, vs_c, br_c, pe_c);
            end
`ifdef VGA_FRAME_TICK_EN
            tests++;
            if ({ft_a, ft_b, ft_c} !== 3'b000) begin
                fails++;
                $display("FAIL reset_ft: got %b%b%b, want 000", ft_a, ft_b, ft_c);
            end
`endif
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    endtask

    task automatic test_pix_cadence();
        int pe_seen[$];
        int bad;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (pe_a === 1'b1) pe_seen.push_back(t_a);
            if (t_a == 3) begin
                tests++;
                if (x_a !== 10'd0) begin
                    fails++;
                    $display("FAIL x_before_first_pix: x=%0d, want 0", x_a);
                end
            end
            if (t_a == 4 || t_a == 8) begin
                tests++;
                if (x_a !== 10'(t_a / 4) || br_a !== 1'b1) begin
                    fails++;
                    $display("FAIL x_step t=%0d: x=%0d br=%b, want x=%0d br=1", t_a, x_a, br_a, t_a / 4);
                end
            end
            if (t_a >= 4 && (hs_a !== 1'b1 || vs_a !== 1'b1 || br_a !== 1'b1)) bad++;
            @(negedge clk);
        end
        tests++;
        if (pe_seen.size() < 3 || pe_seen[0] != 3 || pe_seen[1] != 7 || pe_seen[2] != 11) begin
            fails++;
            $display("FAIL pix_en_cadence: %0d strobes, first at %0d, want strobes at 3 7 11",
                     pe_seen.size(), (pe_seen.size() > 0) ? pe_seen[0] : -1);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL line0_levels: %0d cycles with hs/vs/bright not 1, want 0", bad);
        end
    endtask

    task automatic test_line();
        logic [9:0] prev_x, first_hs_x;
        int start, len, hs_low, br_bad, br_low;
        bit done;
        prev_x = x_a; first_hs_x = '0;
        start = -1; len = 0; hs_low = 0; br_bad = 0; br_low = 0; done = 0;
        for (int i = 0; i < 10000 && !done; i++) begin
            @(negedge clk);
            if (prev_x == 10'd799 && x_a == 10'd0 && start >= 0) begin
                len  = t_a - start;
                done = 1;
            end else begin
                if (prev_x == 10'd799 && x_a == 10'd0) start = t_a;
                if (start >= 0) begin
                    if (hs_a === 1'b0) begin
                        if (hs_low == 0) first_hs_x = x_a;
                        hs_low++;
                    end
                    if (br_a !== ((x_a < 10'd640) && (y_a < 10'd2))) br_bad++;
                    if (br_a === 1'b0) br_low++;
                end
            end
            prev_x = x_a;
        end
        tests++;
        if (!done || len != 3200) begin
            fails++;
            $display("FAIL line_period: got %0d (done=%0d), want 3200", len, done);
        end
        tests++;
        if (hs_low != 384 || first_hs_x !== 10'd656) begin
            fails++;
            $display("FAIL hsync_pulse: low %0d clk from x=%0d, want 384 from 656", hs_low, first_hs_x);
        end
        tests++;
        if (br_bad != 0 || br_low != 640) begin
            fails++;
            $display("FAIL bright_line: %0d wrong cycles, %0d low, want 0 wrong and 640 low", br_bad, br_low);
        end
    endtask

    task automatic test_frame();
        logic [9:0] prev_x, prev_y, fvx, fvy;
        int wt[3];
        int wraps, vs_low, wrap_bad;
`ifdef VGA_FRAME_TICK_EN
        int ft_t[$];
        int ft_bad;
        ft_bad = 0;
`endif
        prev_x = x_a; prev_y = y_a; fvx = '0; fvy = '0;
        wraps = 0; vs_low = 0; wrap_bad = 0;
        for (int i = 0; i < 3; i++) wt[i] = 0;
        for (int i = 0; i < 60000 && wraps < 3; i++) begin
            @(negedge clk);
            if (prev_y == 10'd5 && y_a == 10'd0) begin
                if (prev_x !== 10'd799 || x_a !== 10'd0) wrap_bad++;
                wt[wraps] = t_a;
                wraps++;
            end
            if (wraps == 1 && vs_a === 1'b0) begin
                if (vs_low == 0) begin
                    fvx = x_a;
                    fvy = y_a;
                end
                vs_low++;
            end
`ifdef VGA_FRAME_TICK_EN
            if (wraps >= 1 && wraps < 3 && ft_a === 1'b1) begin
                ft_t.push_back(t_a);
                if (y_a !== 10'd2 || x_a !== 10'd0) ft_bad++;
            end
`endif
            prev_x = x_a;
            prev_y = y_a;
        end
        tests++;
        if (wraps != 3 || wt[1] - wt[0] != 19200 || wt[2] - wt[1] != 19200) begin
            fails++;
            $display("FAIL frame_period: %0d wraps, periods %0d %0d, want 19200 19200",
                     wraps, wt[1] - wt[0], wt[2] - wt[1]);
        end
        tests++;
        if (wrap_bad != 0) begin
            fails++;
            $display("FAIL y_wrap_with_x_wrap: %0d wraps not aligned to x 799->0, want 0", wrap_bad);
        end
        tests++;
        if (vs_low != 6400 || fvy !== 10'd3 || fvx !== 10'd0) begin
            fails++;
            $display("FAIL vsync_pulse: low %0d clk from y=%0d x=%0d, want 6400 from y=3 x=0",
                     vs_low, fvy, fvx);
        end
`ifdef VGA_FRAME_TICK_EN
        tests++;
        if (ft_t.size() != 2 || ft_bad != 0 || ft_t[1] - ft_t[0] != 19200) begin
            fails++;
            $display("FAIL frame_tick: %0d high cycles, %0d misplaced, spacing %0d, want 2 0 19200",
                     ft_t.size(), ft_bad, (ft_t.size() >= 2) ? ft_t[1] - ft_t[0] : -1);
        end
`endif
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit hit;
        int bad;
        hit = 0; bad = 0;
        for (int i = 0; i < 25000 && !hit; i++) begin
            @(negedge clk);
            if (x_a == 10'd700 && y_a == 10'd2 && pe_a === 1'b1) hit = 1;
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL reset_mid_reach: x=700 y=2 never seen, now x=%0d y=%0d", x_a, y_a);
        end
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if ({x_a, y_a, hs_a, vs_a, br_a, pe_a} !== {20'd0, 4'b1100}) begin
            fails++;
            $display("FAIL reset_mid: x=%0d y=%0d hs=%b vs=%b br=%b pe=%b, want 0 0 1 1 0 0",
                     x_a, y_a, hs_a, vs_a, br_a, pe_a);
        end
        rst_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            e = model(t_a, 4, 640, 16, 96, 48, 2, 1, 2, 1);
            if ({x_a, y_a, hs_a, vs_a, br_a, pe_a} !== {e.x, e.y, e.hs, e.vs, e.br, e.pe}) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL restart_after_reset: %0d cycles differ from model, want 0", bad);
        end
    endtask

    task automatic test_pix_div1();
        exp_t e;
        logic [9:0] prev_x;
        int pe_bad, step_bad, mdl_bad, last_wrap, per_bad, nwraps;
        pe_bad = 0; step_bad = 0; mdl_bad = 0; per_bad = 0; nwraps = 0; last_wrap = -1;
        @(negedge clk);
        prev_x = x_b;
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk);
            if (pe_b !== 1'b1) pe_bad++;
            if (x_b !== ((prev_x == 10'd799) ? 10'd0 : prev_x + 10'd1)) step_bad++;
            if (prev_x == 10'd799 && x_b == 10'd0) begin
                if (last_wrap >= 0 && t_b - last_wrap != 800) per_bad++;
                last_wrap = t_b;
                nwraps++;
            end
            e = model(t_b, 1, 640, 16, 96, 48, 4, 1, 2, 1);
            if ({x_b, y_b, hs_b, vs_b, br_b, pe_b} !== {e.x, e.y, e.hs, e.vs, e.br, e.pe}) mdl_bad++;
            prev_x = x_b;
        end
        tests++;
        if (pe_bad != 0) begin
            fails++;
            $display("FAIL div1_pix_en: %0d cycles with pix_en=0, want 0", pe_bad);
        end
        tests++;
        if (step_bad != 0) begin
            fails++;
            $display("FAIL div1_x_step: %0d cycles x did not advance by 1, want 0", step_bad);
        end
        tests++;
        if (nwraps < 2 || per_bad != 0) begin
            fails++;
            $display("FAIL div1_line_period: %0d wraps, %0d periods not 800, want >=2 and 0", nwraps, per_bad);
        end
        tests++;
        if (mdl_bad != 0) begin
            fails++;
            $display("FAIL div1_model: %0d cycles differ from model, want 0", mdl_bad);
        end
    endtask

    task automatic test_random_reset();
        exp_t e;
        int run_len, hold;
        for (int r = 0; r < 6; r++) begin
            run_len = int'($urandom_range(800, 50));
            for (int i = 0; i < run_len; i++) begin
                @(negedge clk);
                e = model(t_c, 3, 20, 3, 5, 4, 10, 2, 3, 4);
                tests++;
                if ({x_c, y_c, hs_c, vs_c, br_c, pe_c} !== {e.x, e.y, e.hs, e.vs, e.br, e.pe}) begin
                    fails++;
                    $display("FAIL rand_model t=%0d: x=%0d y=%0d hs=%b vs=%b br=%b pe=%b, want %0d %0d %b %b %b %b",
                             t_c, x_c, y_c, hs_c, vs_c, br_c, pe_c, e.x, e.y, e.hs, e.vs, e.br, e.pe);
                    break;
                end
`ifdef VGA_FRAME_TICK_EN
                tests++;
                if (ft_c !== e.ft) begin
                    fails++;
                    $display("FAIL rand_frame_tick t=%0d: got %b, want %b", t_c, ft_c, e.ft);
                    break;
                end
`endif
            end
            hold = int'($urandom_range(3, 1));
            rst_c = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                @(negedge clk);
                tests++;
                if ({x_c, y_c, hs_c, vs_c, br_c, pe_c} !== {20'd0, 4'b1100}) begin
                    fails++;
                    $display("FAIL rand_reset: x=%0d y=%0d hs=%b vs=%b br=%b pe=%b, want 0 0 1 1 0 0",
                             x_c, y_c, hs_c, vs_c, br_c, pe_c);
                end
            end
            rst_c = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_pix_cadence();
        test_line();
        test_frame();
        test_reset_mid();
        test_pix_div1();
        test_random_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter PIX_DIV, default 4: clk cycles per pixel; legal range 1..16.
REQ-002 SHALL have parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing, in pixels.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing, in lines.
REQ-004 SHALL have port clk  input  1  system clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port hsync  output  1  horizontal sync, active-low.
REQ-007 SHALL have port vsync  output  1  vertical sync, active-low.
REQ-008 SHALL have port bright  output  1  high while the current pixel is in the visible area.
REQ-009 SHALL have port x  output  10  current horizontal pixel count.
REQ-010 SHALL have port y  output  10  current line count.
REQ-011 SHALL have port pix_en  output  1  one-clk strobe marking the last clk of each pixel.
REQ-012 SHALL have port frame_tick  output  1  one-clk pulse at vertical-blank start; present only under VGA_FRAME_TICK_EN.

Function
REQ-013 SHALL keep a divider counter div running 0..PIX_DIV-1 and wrapping to 0; pix_en SHALL be 1 exactly in cycles where div==PIX_DIV-1.
REQ-014 SHALL hold pix_en constant 1 when PIX_DIV==1.
REQ-015 SHALL define HT=H_ACTIVE+H_FP+H_SYNC+H_BP (800) and VT=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-016 SHALL advance x on each clk edge where pix_en==1; x SHALL wrap from HT-1 to 0.
REQ-017 SHALL advance y when x wraps; y SHALL wrap from VT-1 to 0.
REQ-018 SHALL hold x and y unchanged when pix_en==0.
REQ-019 SHALL register x, y, bright, hsync and vsync together, so all five change on the same clk edge; there SHALL be no cycle with mismatched outputs.
REQ-020 SHALL drive bright=1 iff x<H_ACTIVE and y<V_ACTIVE.
REQ-021 SHALL drive hsync=0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-022 SHALL drive vsync=0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-023 SHALL derive hsync, vsync and bright from the next x/y values, giving zero latency relative to the x/y they accompany.
REQ-024 SHALL guarantee x never exceeds HT-1 and y never exceeds VT-1; unsigned 10-bit arithmetic, no overflow at defaults.

Reset
REQ-025 SHALL, on a clk edge with rst==1, set div=0, x=0, y=0, bright=0, hsync=1, vsync=1, pix_en=0 and frame_tick=0.
REQ-026 SHALL let rst override any concurrent pix_en or wrap event, including rst asserted mid-line or mid-frame.
REQ-027 SHALL, after the rst edge, produce the first pix_en PIX_DIV-1 cycles after rst deasserts, with x becoming 1 on that edge; bright SHALL become 1 on the first pix_en edge with x<H_ACTIVE.

Configuration
REQ-028 SHALL, with VGA_FRAME_TICK_EN defined, include port frame_tick, registered, 1 for exactly one clk after the edge on which y becomes V_ACTIVE and x becomes 0; this gives one pulse per frame.
REQ-029 SHALL, without VGA_FRAME_TICK_EN, omit port frame_tick and its logic entirely; all other behaviour SHALL be identical.

Verification
REQ-030 SHALL cover: PIX_DIV=4, rst held 3 cycles then released -> pix_en at cycles 3, 7, 11...; x steps 0->1->2; hsync=1, vsync=1, bright=1 while y=0.
REQ-031 SHALL cover: run one line -> line period 3200 clk; hsync low for 384 clk starting when x=656; bright low for x in 640..799.
REQ-032 SHALL cover: run one frame -> frame period 1,680,000 clk; vsync low for 2 lines (6400 clk) at y=490..491; y wraps 524->0 when x wraps 799->0.
REQ-033 SHALL cover: VGA_FRAME_TICK_EN defined, two frames -> exactly two single-clk frame_tick pulses, spaced 1,680,000 clk, each coincident with y=480, x=0.
REQ-034 SHALL cover: rst asserted at x=700, y=300 -> next edge gives x=0, y=0, hsync=1, vsync=1, bright=0, pix_en=0, and the count restarts per REQ-027.
REQ-035 SHALL cover: PIX_DIV=1 -> pix_en constantly 1; x increments every clk; line period 800 clk.
